soc_run_checker: RTL
====================

SOC_RUN_CHECKER -- requirements
Module: soc_run_checker

Interface
REQ-001 SHALL have parameter DATA_W, default 32: width of the PC, register data and expected values.
REQ-002 SHALL have parameter RA_W, default 5: width of the register-file read index.
REQ-003 SHALL have parameter NUM_REGS, default 32: number of expectation-table entries, and SHALL require NUM_REGS <= 2**RA_W.
REQ-004 SHALL have parameter RST_CYCLES, default 5: number of cycles the SoC reset is held, and SHALL require RST_CYCLES >= 1.
REQ-005 SHALL have parameter CNT_W, default 16: width of the cycle counter and the timeout value.
REQ-006 SHALL have port clk, input, 1: clock; all state SHALL update on its rising edge.
REQ-007 SHALL have port rst, input, 1: reset, synchronous, active-low.
REQ-008 SHALL have port start, input, 1: single-cycle request to begin a run.
REQ-009 SHALL have port halt_pc, input, DATA_W: PC value that ends a run; sampled at start.
REQ-010 SHALL have port timeout, input, CNT_W: maximum number of RUN cycles; sampled at start.
REQ-011 SHALL have port exp_we, input, 1: expectation-table write strobe.
REQ-012 SHALL have port exp_idx, input, RA_W: expectation-table write index.
REQ-013 SHALL have port exp_val, input, DATA_W: expectation-table write value.
REQ-014 SHALL have port exp_clr, input, 1: clears every valid bit in the expectation table.
REQ-015 SHALL have port pc_current, input, DATA_W: SoC program counter.
REQ-016 SHALL have port rd, input, DATA_W: SoC register-file debug read data, combinational from ra.
REQ-017 SHALL have port soc_rst, output, 1: active-high reset to the SoC.
REQ-018 SHALL have port ra, output, RA_W: SoC register-file debug read index; registered.
REQ-019 SHALL have outputs busy, done, pass, fail, each 1 bit: run status.
REQ-020 SHALL have output fail_code, 2 bits: 0 = none, 1 = timeout, 2 = register mismatch.
REQ-021 SHALL have outputs fail_idx (RA_W) and fail_got (DATA_W): first mismatching register index and the value read from it.
REQ-022 SHALL have output cycles, CNT_W: RUN-cycle count of the most recent run.

Function
REQ-023 SHALL hold a table of NUM_REGS entries, each a valid bit plus a DATA_W value.
REQ-024 SHALL, on exp_we with exp_idx < NUM_REGS while busy=0, write exp_val to the entry and set its valid bit; writes with exp_idx >= NUM_REGS SHALL be ignored.
REQ-025 SHALL, on exp_clr while busy=0, clear all valid bits; if exp_clr and exp_we occur in the same cycle, exp_clr is applied first and then the write, so the written entry ends valid.
REQ-026 SHALL ignore exp_we and exp_clr while busy=1.
REQ-027 SHALL implement the FSM states IDLE, RST_HOLD, RUN, CHK_SET, CHK_CMP, DONE.
REQ-028 SHALL, on start in IDLE or DONE, do all of the following: latch halt_pc and timeout; clear cycles, pass, fail, fail_code, fail_idx, fail_got and done; enter RST_HOLD.
REQ-029 SHALL ignore start in any other state.
REQ-030 SHALL drive soc_rst=1 for exactly RST_CYCLES cycles while in RST_HOLD, then enter RUN with soc_rst=0.
REQ-031 SHALL, in RUN, leave cycles unchanged on a cycle where pc_current equals the latched halt_pc, and enter CHK_SET with the check index set to 0.
REQ-032 SHALL, in RUN on a cycle with no halt match, increment cycles, saturating at 2**CNT_W-1.
REQ-033 SHALL, in RUN on a cycle with no halt match where cycles already equals the latched timeout, set fail_code=1 and enter DONE.
REQ-034 SHALL give a halt match priority over a timeout occurring in the same cycle.
REQ-035 SHALL, in CHK_SET with an invalid entry at the current index, advance the index (one cycle per skipped entry).
REQ-036 SHALL, in CHK_SET with a valid entry, set ra to the index and enter CHK_CMP.
REQ-037 SHALL, at the end of CHK_CMP, compare rd with the expected value.
REQ-038 SHALL, on a CHK_CMP mismatch, capture fail_idx and fail_got, set fail_code=2, and enter DONE.
REQ-039 SHALL, on a CHK_CMP match, advance the index and return to CHK_SET.
REQ-040 SHALL, after the last index (NUM_REGS-1) is processed without a mismatch, set pass=1 and enter DONE.
REQ-041 SHALL, in DONE, hold done=1, hold fail=(fail_code!=0) and hold all results until the next start.
REQ-042 SHALL hold busy=1 in RST_HOLD, RUN, CHK_SET and CHK_CMP, and busy=0 in IDLE and DONE.
REQ-043 SHALL have pass and fail never asserted simultaneously.
REQ-044 SHALL drive soc_rst=0 in all states except RST_HOLD.

Reset
REQ-045 SHALL, on rst=0 at a clock edge, do all of the following, including mid-run: enter IDLE; clear all table valid bits; drive soc_rst=0, ra=0, busy=0, done=0, pass=0, fail=0, fail_code=0, fail_idx=0, fail_got=0 and cycles=0.

Verification
REQ-046 SHALL verify the clean pass: table {2:0x5, 31:0xDEADBEEF}, halt_pc=0x100, PC reaches 0x100 after 40 cycles, rd matches -> pass=1, fail_code=0, cycles=40.
REQ-047 SHALL verify timeout: timeout=10, PC never matches -> done=1, fail_code=1, cycles=10, soc_rst high for exactly 5 cycles after start.
REQ-048 SHALL verify mismatch: entries 3:0x7 and 4:0x9, rd returns 0x8 at ra=3 -> fail_code=2, fail_idx=3, fail_got=0x8, entry 4 never driven on ra.
REQ-049 SHALL verify the halt/timeout tie: halt match on the same cycle cycles==timeout -> check phase entered, pass=1.
REQ-050 SHALL verify an empty table: exp_clr, then run -> pass=1 after NUM_REGS CHK_SET cycles; exp_we during busy ignored.
REQ-051 SHALL verify reset mid-RUN: rst=0 -> all outputs zero and table invalid; a start after release performs a full run.

Source files
------------

// File: rtl/soc_run_checker.sv
// Runs a SoC from reset until it reaches a halt PC or times out, then checks selected registers against an expectation table.
// Status outputs hold until the next start.
module soc_run_checker #(
    parameter int DATA_W     = 32,
    parameter int RA_W       = 5,
    parameter int NUM_REGS   = 32,
    parameter int RST_CYCLES = 5,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] halt_pc,
    input  logic [CNT_W-1:0]  timeout,
    input  logic              exp_we,
    input  logic [RA_W-1:0]   exp_idx,
    input  logic [DATA_W-1:0] exp_val,
    input  logic              exp_clr,
    input  logic [DATA_W-1:0] pc_current,
    input  logic [DATA_W-1:0] rd,
    output logic              soc_rst,
    output logic [RA_W-1:0]   ra,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic [1:0]        fail_code,
    output logic [RA_W-1:0]   fail_idx,
    output logic [DATA_W-1:0] fail_got,
    output logic [CNT_W-1:0]  cycles
);

    if (NUM_REGS > 2**RA_W) begin : g_bad_num_regs
        $error("soc_run_checker: NUM_REGS must not exceed 2**RA_W");
    end
    if (RST_CYCLES < 1) begin : g_bad_rst_cycles
        $error("soc_run_checker: RST_CYCLES must be at least 1");
    end

    localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RC_W-1:0] RST_LAST = RC_W'(RST_CYCLES - 1);
    localparam logic [RA_W-1:0] IDX_LAST = RA_W'(NUM_REGS - 1);
    localparam logic [RA_W:0]   NUM_REGS_W = (RA_W + 1)'(NUM_REGS);

    localparam logic [1:0] FC_NONE     = 2'd0;
    localparam logic [1:0] FC_TIMEOUT  = 2'd1;
    localparam logic [1:0] FC_MISMATCH = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        RST_HOLD,
        RUN,
        CHK_SET,
        CHK_CMP,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [NUM_REGS-1:0] valid;
    logic [DATA_W-1:0]   exp_tab [NUM_REGS];
    logic [DATA_W-1:0]   halt_q;
    logic [CNT_W-1:0]    timeout_q;
    logic [RC_W-1:0]     rst_cnt;
    logic [RA_W-1:0]     idx;

    logic halt_hit, tmo_hit, last_idx, cur_vld, mismatch, tab_wr_ok;

    assign halt_hit  = (pc_current == halt_q);
    assign tmo_hit   = (cycles == timeout_q);
    assign last_idx  = (idx == IDX_LAST);
    assign cur_vld   = valid[idx];
    assign mismatch  = (rd != exp_tab[idx]);
    assign tab_wr_ok = !busy && exp_we && ({1'b0, exp_idx} < NUM_REGS_W);

    assign busy    = (state == RST_HOLD) || (state == RUN) || (state == CHK_SET) || (state == CHK_CMP);
    assign done    = (state == DONE);
    assign soc_rst = (state == RST_HOLD);
    assign fail    = (fail_code != FC_NONE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start) state_nxt = RST_HOLD;
            RST_HOLD:   if (rst_cnt == RST_LAST) state_nxt = RUN;
            RUN: begin
                // A halt seen on the timeout cycle still counts as a clean finish.
                if (halt_hit)     state_nxt = CHK_SET;
                else if (tmo_hit) state_nxt = DONE;
            end
            CHK_SET: begin
                if (cur_vld)       state_nxt = CHK_CMP;
                else if (last_idx) state_nxt = DONE;
            end
            CHK_CMP: begin
                if (mismatch || last_idx) state_nxt = DONE;
                else                      state_nxt = CHK_SET;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid     <= '0;
            halt_q    <= '0;
            timeout_q <= '0;
            rst_cnt   <= '0;
            idx       <= '0;
            ra        <= '0;
            pass      <= 1'b0;
            fail_code <= FC_NONE;
            fail_idx  <= '0;
            fail_got  <= '0;
            cycles    <= '0;
        end else begin
            // Clear first so a same-cycle write leaves its entry valid.
            if (!busy && exp_clr) valid <= '0;
            if (tab_wr_ok) valid[exp_idx] <= 1'b1;

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        halt_q    <= halt_pc;
                        timeout_q <= timeout;
                        rst_cnt   <= '0;
                        pass      <= 1'b0;
                        fail_code <= FC_NONE;
                        fail_idx  <= '0;
                        fail_got  <= '0;
                        cycles    <= '0;
                    end
                end
                RST_HOLD: rst_cnt <= rst_cnt + 1'b1;
                RUN: begin
                    if (halt_hit)         idx <= '0;
                    else if (tmo_hit)     fail_code <= FC_TIMEOUT;
                    else if (cycles != '1) cycles <= cycles + 1'b1;
                end
                CHK_SET: begin
                    if (cur_vld)       ra <= idx;
                    else if (last_idx) pass <= 1'b1;
                    else               idx <= idx + 1'b1;
                end
                CHK_CMP: begin
                    if (mismatch) begin
                        fail_idx  <= idx;
                        fail_got  <= rd;
                        fail_code <= FC_MISMATCH;
                    end else if (last_idx) begin
                        pass <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Table data needs no reset: entries are only read when their valid bit is set.
    always_ff @(posedge clk) begin
        if (tab_wr_ok) exp_tab[exp_idx] <= exp_val;
    end

endmodule
